// File: rtl/input_debounce_pkg.sv
// Shared constants for the two-channel switch debouncer.
// Hardware defaults target 10 ms at 100 MHz; the sim constant keeps benches short.
package input_debounce_pkg;

    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int CNT_W_DEFAULT     = 20;
    localparam int DB_CYCLES_SIM     = 4;

    // True when a counter of width w can reach n without wrapping.
    function automatic bit cnt_fits(input int w, input int n);
        return (64'(1) << w) >= 64'(n);
    endfunction

endpackage

// File: rtl/input_debounce_2_ch.sv
// One debounce channel: two-flop synchronizer, persistence counter,
// accepted level register and registered rise pulse.
module debounce_ch
    import input_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("debounce_ch: DB_CYCLES must be at least 2");
    end

    if (!cnt_fits(CNT_W, DB_CYCLES)) begin : g_bad_w
        $error("debounce_ch: CNT_W too narrow for DB_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             done;

    assign differ = s2 != level;
    assign done   = differ && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Count consecutive mismatches; the final one is accepted and clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!differ || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= done && s2;
            if (done) begin
                level <= s2;
            end
        end
    end

endmodule

// File: rtl/input_debounce_2.sv
// Two independent debounced switch inputs with rise pulses.
// Each channel carries its own synchronizer and counter.
module input_debounce_2
    import input_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise
);

    debounce_ch #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_ch_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (a_raw),
        .level (a),
        .rise  (a_rise)
    );

    debounce_ch #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_ch_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (b_raw),
        .level (b),
        .rise  (b_rise)
    );

endmodule
